// File: rtl/qu_instr_decoder.sv
// rtl/qu_instr_decoder.sv - RV32I decode stage with a 2-entry registered skid buffer
module qu_instr_decoder #(
  parameter int PC_WIDTH  = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0]           optype_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [31:0]          imm_o,
  output logic                 rd_valid_o,
  output logic                 rs1_valid_o,
  output logic                 rs2_valid_o,
  output logic                 imm_valid_o,
  output logic                 illegal_o,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic [CNT_WIDTH-1:0] illegal_cnt_o
);

  typedef struct packed {
    logic [3:0]          optype;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic                rd_valid;
    logic                rs1_valid;
    logic                rs2_valid;
    logic                imm_valid;
    logic                illegal;
    logic [PC_WIDTH-1:0] pc;
  } bundle_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  bundle_t     dec;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        bad, wr_rd, use_rs1, use_rs2, use_imm;

  always_comb begin
    cls     = 4'd15;
    imm     = 32'h0;
    bad     = 1'b0;
    wr_rd   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_imm = 1'b1;
    case (instr_i[6:0])
      OPC_R: begin
        cls = 4'd0; wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b0;
        bad = !((f7 == 7'h00) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_IMM: begin
        cls = 4'd1; wr_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        bad = (f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != F7_ALT);
      end
      OPC_LOAD: begin
        cls = 4'd2; wr_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        cls = 4'd3; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
        bad = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        cls = 4'd4; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL:   begin cls = 4'd5; wr_rd = 1'b1; imm = imm_j; end
      OPC_JALR: begin
        cls = 4'd6; wr_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        bad = (f3 != 3'b000);
      end
      OPC_LUI:   begin cls = 4'd7; wr_rd = 1'b1; imm = imm_u; end
      OPC_AUIPC: begin cls = 4'd8; wr_rd = 1'b1; imm = imm_u; end
      OPC_SYSTEM: begin
        // funct3=000 covers ECALL/EBREAK only; every other legal funct3 is a CSR op
        cls = 4'd9; imm = imm_i;
        wr_rd   = (f3 != 3'b000);
        use_rs1 = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
        bad = (f3 == 3'b100) || (f3 == 3'b000 && instr_i[31:20] > 12'd1);
      end
      OPC_FENCE: begin
        cls = 4'd10; use_imm = 1'b0;
        bad = (f3 > 3'b001);
      end
      default: bad = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) bad = 1'b1;

    dec.rd        = instr_i[11:7];
    dec.rs1       = instr_i[19:15];
    dec.rs2       = instr_i[24:20];
    dec.funct3    = f3;
    dec.funct7    = f7;
    dec.pc        = pc_i;
    dec.illegal   = bad;
    dec.optype    = bad ? 4'd15 : cls;
    dec.imm       = bad ? 32'h0 : imm;
    dec.rd_valid  = !bad && wr_rd && (instr_i[11:7] != 5'd0);
    dec.rs1_valid = !bad && use_rs1;
    dec.rs2_valid = !bad && use_rs2;
    dec.imm_valid = !bad && use_imm;
  end

  bundle_t               e0, e1;
  logic                  e0_valid, e1_valid;
  logic [CNT_WIDTH-1:0]  illegal_cnt;
  logic                  accept, xfer;

  assign in_ready_o = !e1_valid;
  assign accept     = in_valid_i && in_ready_o;
  assign xfer       = e0_valid && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_valid    <= 1'b0;
      e1_valid    <= 1'b0;
      e0          <= '0;
      e1          <= '0;
      illegal_cnt <= '0;
    end else begin
      // a transfer coinciding with flush still happened downstream, so it is counted
      if (xfer && e0.illegal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_ONE;
      if (flush_i) begin
        e0_valid <= 1'b0;
        e1_valid <= 1'b0;
      end else if (xfer) begin
        if (e1_valid) begin
          e0       <= e1;
          e1_valid <= 1'b0;
        end else if (accept) begin
          e0 <= dec;
        end else begin
          e0_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!e0_valid) begin
          e0       <= dec;
          e0_valid <= 1'b1;
        end else begin
          e1       <= dec;
          e1_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid_o   = e0_valid;
  assign optype_o      = e0.optype;
  assign rd_o          = e0.rd;
  assign rs1_o         = e0.rs1;
  assign rs2_o         = e0.rs2;
  assign funct3_o      = e0.funct3;
  assign funct7_o      = e0.funct7;
  assign imm_o         = e0.imm;
  assign rd_valid_o    = e0.rd_valid;
  assign rs1_valid_o   = e0.rs1_valid;
  assign rs2_valid_o   = e0.rs2_valid;
  assign imm_valid_o   = e0.imm_valid;
  assign illegal_o     = e0.illegal;
  assign pc_o          = e0.pc;
  assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_qu_instr_decoder.sv
// tb/tb_qu_instr_decoder.sv - scoreboard bench for qu_instr_decoder
module tb_qu_instr_decoder;
  localparam int PW = 12;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0]   instr_i, imm_o;
  logic [PW-1:0] pc_i, pc_o;
  logic [3:0]    optype_o;
  logic [4:0]    rd_o, rs1_o, rs2_o;
  logic [2:0]    funct3_o;
  logic [6:0]    funct7_o;
  logic          rd_valid_o, rs1_valid_o, rs2_valid_o, imm_valid_o, illegal_o;
  logic [CW-1:0] illegal_cnt_o;

  qu_instr_decoder #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .optype_o(optype_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
    .rd_valid_o(rd_valid_o), .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
    .imm_valid_o(imm_valid_o), .illegal_o(illegal_o), .pc_o(pc_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  // narrow-counter instance used only to reach saturation quickly
  logic          s_in_valid, s_in_ready, s_out_valid;
  logic [31:0]   s_instr, s_imm;
  logic [PW-1:0] s_pc, s_pc_o;
  logic [3:0]    s_optype;
  logic [4:0]    s_rd, s_rs1, s_rs2;
  logic [2:0]    s_f3;
  logic [6:0]    s_f7;
  logic          s_rdv, s_rs1v, s_rs2v, s_immv, s_ill;
  logic [2:0]    s_cnt;

  qu_instr_decoder #(.PC_WIDTH(PW), .CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .instr_i(s_instr), .pc_i(s_pc),
    .out_valid_o(s_out_valid), .out_ready_i(1'b1),
    .optype_o(s_optype), .rd_o(s_rd), .rs1_o(s_rs1), .rs2_o(s_rs2),
    .funct3_o(s_f3), .funct7_o(s_f7), .imm_o(s_imm),
    .rd_valid_o(s_rdv), .rs1_valid_o(s_rs1v), .rs2_valid_o(s_rs2v),
    .imm_valid_o(s_immv), .illegal_o(s_ill), .pc_o(s_pc_o),
    .illegal_cnt_o(s_cnt)
  );

  typedef struct packed {
    logic [31:0]   instr;
    logic [PW-1:0] pc;
    logic [3:0]    optype;
    logic [31:0]   imm;
    logic [4:0]    flags;  // {rd_v, rs1_v, rs2_v, imm_v, illegal}
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b1;
  logic [15:0] exp_cnt = 16'h0;
  logic [PW-1:0] pc_next = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [PW-1:0] pc,
                              input logic [3:0] op, input logic [31:0] imm, input logic [4:0] fl);
    exp_t e;
    e.instr = ins; e.pc = pc; e.optype = op; e.imm = imm; e.flags = fl;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [PW-1:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, wr, r1, r2, iv;
    logic [31:0] ii, is, ib, iu, ij, im;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = 32'($signed(ins) >>> 20);
    is = {ii[31:5], ins[11:7]};
    ib = {ii[31:12], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {ii[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
    ok = 1'b1; wr = 1'b0; r1 = 1'b0; r2 = 1'b0; iv = 1'b1; im = 32'h0;
    e.instr = ins; e.pc = pc; e.optype = 4'd15;
    case (ins[6:0])
      7'h33: begin e.optype = 4'd0; wr = 1; r1 = 1; r2 = 1; iv = 0;
                   ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
      7'h13: begin e.optype = 4'd1; wr = 1; r1 = 1; im = ii;
                   if (f3 == 3'd1) ok = (f7 == 7'h00);
                   if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20); end
      7'h03: begin e.optype = 4'd2; wr = 1; r1 = 1; im = ii;
                   ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      7'h23: begin e.optype = 4'd3; r1 = 1; r2 = 1; im = is; ok = (f3 <= 3'd2); end
      7'h63: begin e.optype = 4'd4; r1 = 1; r2 = 1; im = ib; ok = !(f3 == 3'd2 || f3 == 3'd3); end
      7'h6F: begin e.optype = 4'd5; wr = 1; im = ij; end
      7'h67: begin e.optype = 4'd6; wr = 1; r1 = 1; im = ii; ok = (f3 == 3'd0); end
      7'h37: begin e.optype = 4'd7; wr = 1; im = iu; end
      7'h17: begin e.optype = 4'd8; wr = 1; im = iu; end
      7'h73: begin e.optype = 4'd9; im = ii; wr = (f3 != 3'd0); r1 = (f3 >= 3'd1 && f3 <= 3'd3);
                   if (f3 == 3'd4) ok = 0;
                   if (f3 == 3'd0 && ins[31:20] > 12'd1) ok = 0; end
      7'h0F: begin e.optype = 4'd10; iv = 0; ok = (f3 <= 3'd1); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.optype = 4'd15; e.imm = 32'h0; e.flags = 5'b00001;
    end else begin
      e.imm = im;
      e.flags = {wr && (ins[11:7] != 5'd0), r1, r2, iv, 1'b0};
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 11);
    if (k == 11) return ins;
    ins[6:0] = opc[k];
    case ($urandom_range(0, 2))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      default: ;
    endcase
    if (k == 9 && $urandom_range(0, 1) == 1) begin
      ins[14:12] = 3'd0;
      ins[31:21] = 11'd0;
    end
    return ins;
  endfunction

  task automatic send(input logic [31:0] ins, input exp_t e);
    int budget = 200;
    @(negedge clk);
    in_valid_i = 1'b1;
    instr_i    = ins;
    pc_i       = e.pc;
    while (!in_ready_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] ins);
    send(ins, model(ins, pc_next));
    pc_next = pc_next + PW'(4);
  endtask

  task automatic send_exp(input logic [31:0] ins, input logic [3:0] op,
                          input logic [31:0] imm, input logic [4:0] fl);
    send(ins, mk(ins, pc_next, op, imm, fl));
    pc_next = pc_next + PW'(4);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // output monitor: pops the scoreboard on every output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_pc", 32'(pc_o), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("optype", 32'(optype_o), 32'(e.optype));
          check("rd", 32'(rd_o), 32'(e.instr[11:7]));
          check("rs1", 32'(rs1_o), 32'(e.instr[19:15]));
          check("rs2", 32'(rs2_o), 32'(e.instr[24:20]));
          check("funct3", 32'(funct3_o), 32'(e.instr[14:12]));
          check("funct7", 32'(funct7_o), 32'(e.instr[31:25]));
          check("flags", 32'({rd_valid_o, rs1_valid_o, rs2_valid_o, imm_valid_o, illegal_o}),
                32'(e.flags));
          if (!e.flags[0]) check("imm", imm_o, e.imm);
          check("pc", 32'(pc_o), 32'(e.pc));
          if (e.flags[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  logic rnd_rdy;
  logic [PW-1:0] pc_a;
  logic [15:0] want_cnt;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    instr_i = 32'h0; pc_i = '0;
    s_in_valid = 1'b0; s_instr = 32'h0; s_pc = '0;
    #12;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_cnt", 32'(illegal_cnt_o), 32'd0);
    check("rst_optype", 32'(optype_o), 32'd0);
    check("rst_imm", imm_o, 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed decodes
    send_exp(32'hFFF10093, 4'd1, 32'hFFFFFFFF, 5'b11010);
    check("latency", 32'(out_valid_o), 32'd1);
    send_exp(32'hFE208EE3, 4'd4, 32'hFFFFFFFC, 5'b01110);
    send_exp(32'h123452B7, 4'd7, 32'h12345000, 5'b10010);
    send_exp(32'h00000037, 4'd7, 32'h00000000, 5'b00010);
    send_exp(32'h00000000, 4'd15, 32'h0, 5'b00001);
    send_exp(32'h40001033, 4'd15, 32'h0, 5'b00001);
    drain();
    check("illegal_cnt_two", 32'(illegal_cnt_o), 32'd2);
    send_exp(32'h008000EF, 4'd5, 32'h00000008, 5'b10010);
    send_exp(32'h0020A223, 4'd3, 32'h00000004, 5'b01110);
    send_exp(32'h00100073, 4'd9, 32'h00000001, 5'b00010);
    send_exp(32'h00200073, 4'd15, 32'h0, 5'b00001);
    drain();
    check("illegal_cnt_directed", 32'(illegal_cnt_o), 32'(exp_cnt));

    // backpressure: A and B buffered, C held off until the sink opens
    out_ready_i = 1'b0;
    pc_a = pc_next;
    send_model(32'h00108093);
    send_model(32'h00210113);
    check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
    fork
      send_model(32'h00318193);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_c_held", 32'(in_ready_o), 32'd0);
          check("bp_a_stable", 32'(pc_o), 32'(pc_a));
        end
        out_ready_i = 1'b1;
      end
    join
    drain();

    // random stream with random sink stalls
    rnd_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send_model(gen_instr());
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rnd_rdy = 1'b0;
      end
      begin
        while (rnd_rdy) begin
          @(negedge clk);
          out_ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready_i = 1'b1;
    drain();
    check("illegal_cnt_random", 32'(illegal_cnt_o), 32'(exp_cnt));

    // flush with both entries full and an instruction offered
    out_ready_i = 1'b0;
    send_model(32'h00500293);
    send_model(32'h00600313);
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    flush_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h00700393; pc_i = 12'hABC;
    @(posedge clk);
    #1 flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_in_ready", 32'(in_ready_o), 32'd1);
    mon_en = 1'b1;
    out_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("flush_nothing_out", 32'(out_valid_o), 32'd0);

    // flush coinciding with the transfer of an illegal entry, with input offered
    out_ready_i = 1'b0;
    mon_en = 1'b0;
    send_model(32'hFFFFFFFF);
    exp_q.delete();
    want_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h00800413; pc_i = 12'h123;
    @(posedge clk);
    #1 flush_i = 1'b0; in_valid_i = 1'b0;
    check("flushx_out_valid", 32'(out_valid_o), 32'd0);
    check("flushx_in_ready", 32'(in_ready_o), 32'd1);
    check("flushx_cnt", 32'(illegal_cnt_o), 32'(want_cnt));
    exp_cnt = want_cnt;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // asynchronous reset mid-stream
    out_ready_i = 1'b0;
    send_model(32'h00900493);
    send_model(32'h00A00513);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_o), 32'd0);
    check("arst_in_ready", 32'(in_ready_o), 32'd1);
    check("arst_cnt", 32'(illegal_cnt_o), 32'd0);
    check("arst_pc", 32'(pc_o), 32'd0);
    exp_q.delete();
    exp_cnt = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    send_model(32'h00B00593);
    drain();

    // counter saturation on the narrow instance
    @(negedge clk);
    s_in_valid = 1'b1; s_instr = 32'h00000000;
    repeat (9) @(negedge clk);
    s_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_cnt", 32'(s_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
